// File: rtl/mesh_switch_allocator_pkg.sv
// Shared mesh constants: port count, port indices and starvation threshold.
package mesh_switch_allocator_pkg;

  localparam int unsigned MESH_N_PORTS     = 5;
  localparam int unsigned MESH_STALL_LIMIT = 255;
  localparam int unsigned STALL_CNT_W      = 8;

  // Port order of the router: local core first, then the four compass links.
  localparam int unsigned CORE  = 0;
  localparam int unsigned NORTH = 1;
  localparam int unsigned EAST  = 2;
  localparam int unsigned SOUTH = 3;
  localparam int unsigned WEST  = 4;

endpackage

// File: rtl/mesh_switch_allocator_if.sv
// Request/grant bundle between the input FIFOs, route calculator, crossbar and allocator.
interface mesh_switch_allocator_if
  import mesh_switch_allocator_pkg::*;
#(
  parameter int unsigned N_PORTS = MESH_N_PORTS
);

  logic [N_PORTS-1:0][N_PORTS-1:0] i_req;       // one-hot output request per input head
  logic [N_PORTS-1:0]              i_req_val;   // input head valid
  logic [N_PORTS-1:0]              i_en;        // downstream accepts per output
  logic [N_PORTS-1:0]              o_pop;       // input FIFO read enable
  logic [N_PORTS-1:0][N_PORTS-1:0] o_sel;       // one-hot input select per output
  logic [N_PORTS-1:0]              o_data_val;  // output register valid
  logic [N_PORTS-1:0]              o_stall;     // starvation flag per output
  logic                            o_err;       // sticky malformed-request flag

  modport master (
    output i_req, i_req_val, i_en,
    input  o_pop, o_sel, o_data_val, o_stall, o_err
  );

  modport slave (
    input  i_req, i_req_val, i_en,
    output o_pop, o_sel, o_data_val, o_stall, o_err
  );

endinterface

// File: rtl/mesh_rr_arbiter.sv
// Round-robin arbiter for one output port: rotating pointer plus priority search.
module mesh_rr_arbiter
  import mesh_switch_allocator_pkg::*;
#(
  parameter int unsigned N_PORTS = MESH_N_PORTS
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [N_PORTS-1:0] req,
  input  logic               en,
  output logic [N_PORTS-1:0] gnt_c
);

  localparam int unsigned      PTR_W = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;
  localparam logic [PTR_W-1:0] LAST  = PTR_W'(N_PORTS - 1);

  logic [PTR_W-1:0] ptr_q, ptr_d;
  logic [PTR_W-1:0] idx, nxt;
  logic             found;

  // Search from ptr upward with wrap; winner's successor becomes the new pointer.
  always_comb begin
    gnt_c = '0;
    ptr_d = ptr_q;
    found = 1'b0;
    idx   = ptr_q;
    nxt   = '0;
    for (int unsigned i = 0; i < N_PORTS; i++) begin
      nxt = (idx == LAST) ? '0 : idx + PTR_W'(1);
      if (!found && req[idx] && en && reset_n) begin
        gnt_c[idx] = 1'b1;
        ptr_d      = nxt;
        found      = 1'b1;
      end
      idx = nxt;
    end
  end

  // Pointer register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/mesh_switch_allocator.sv
// Switch allocator for a mesh router: per-output round-robin grant, pop/select, stall and error tracking.
module mesh_switch_allocator
  import mesh_switch_allocator_pkg::*;
#(
  parameter int unsigned N_PORTS     = MESH_N_PORTS,
  parameter int unsigned STALL_LIMIT = MESH_STALL_LIMIT
) (
  input logic                    clk,
  input logic                    reset_n,
  mesh_switch_allocator_if.slave bus
);

  localparam logic [STALL_CNT_W-1:0] LIMIT = STALL_CNT_W'(STALL_LIMIT);

  logic [N_PORTS-1:0]     route_c [N_PORTS];   // route_c[j][k]: input k validly requests output j
  logic [N_PORTS-1:0]     gnt_c   [N_PORTS];
  logic                   malformed_c;
  logic [N_PORTS-1:0]     data_val_q, data_val_d;
  logic [N_PORTS-1:0]     stall_q, stall_d;
  logic [STALL_CNT_W-1:0] stall_cnt_q [N_PORTS];
  logic [STALL_CNT_W-1:0] stall_cnt_d [N_PORTS];
  logic                   err_q, err_d;

  // Decode heads: only an exactly one-hot request counts; zero is idle, multi-hot is an error.
  always_comb begin
    malformed_c = 1'b0;
    for (int unsigned j = 0; j < N_PORTS; j++) begin
      route_c[j] = '0;
    end
    for (int unsigned k = 0; k < N_PORTS; k++) begin
      if (bus.i_req_val[k]) begin
        if ($onehot(bus.i_req[k])) begin
          for (int unsigned j = 0; j < N_PORTS; j++) begin
            route_c[j][k] = bus.i_req[k][j];
          end
        end else if (bus.i_req[k] != '0) begin
          malformed_c = 1'b1;
        end
      end
    end
  end

  for (genvar j = 0; j < N_PORTS; j++) begin : g_arb
    mesh_rr_arbiter #(.N_PORTS(N_PORTS)) u_arb (
      .clk    (clk),
      .reset_n(reset_n),
      .req    (route_c[j]),
      .en     (bus.i_en[j]),
      .gnt_c  (gnt_c[j])
    );
  end

  // Zero-latency crossbar select and FIFO pop; an input targets one output so ORing is exact.
  always_comb begin
    bus.o_pop = '0;
    for (int unsigned j = 0; j < N_PORTS; j++) begin
      bus.o_sel[j] = gnt_c[j];
      bus.o_pop    = bus.o_pop | gnt_c[j];
    end
  end

  // Next state: output valid follows grant, saturating stall counters, sticky error.
  always_comb begin
    data_val_d = '0;
    stall_d    = '0;
    err_d      = err_q | malformed_c;
    for (int unsigned j = 0; j < N_PORTS; j++) begin
      stall_cnt_d[j] = '0;
      data_val_d[j]  = |gnt_c[j];
      if ((|route_c[j]) && !bus.i_en[j]) begin
        stall_cnt_d[j] = (stall_cnt_q[j] == LIMIT) ? stall_cnt_q[j]
                                                   : stall_cnt_q[j] + STALL_CNT_W'(1);
      end
      stall_d[j] = (stall_cnt_d[j] == LIMIT);
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_val_q <= '0;
      stall_q    <= '0;
      err_q      <= 1'b0;
      for (int unsigned j = 0; j < N_PORTS; j++) begin
        stall_cnt_q[j] <= '0;
      end
    end else begin
      data_val_q <= data_val_d;
      stall_q    <= stall_d;
      err_q      <= err_d;
      for (int unsigned j = 0; j < N_PORTS; j++) begin
        stall_cnt_q[j] <= stall_cnt_d[j];
      end
    end
  end

  assign bus.o_data_val = data_val_q;
  assign bus.o_stall    = stall_q;
  assign bus.o_err      = err_q;

endmodule

// File: doc/mesh_switch_allocator.md
MESH_SWITCH_ALLOCATOR -- requirements
Module: mesh_switch_allocator

Interface
REQ-001 Parameter N_PORTS, default 5, SHALL set the port count; port order is [core, north, east, south, west].
REQ-002 Parameter STALL_LIMIT, default 255, SHALL set the starvation-detect threshold in cycles (8-bit).
REQ-003 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 reset_n  input  1  SHALL be the reset: asynchronous, active-low.
REQ-005 i_req [0:N_PORTS-1]  input  N_PORTS each  SHALL be the one-hot output-port request of each input FIFO head, from the route calculator.
REQ-006 i_req_val [0:N_PORTS-1]  input  1 each  SHALL mean the input FIFO head is valid.
REQ-007 i_en [0:N_PORTS-1]  input  1 each  SHALL mean the downstream port accepts data this cycle.
REQ-008 o_pop [0:N_PORTS-1]  output  1 each  SHALL be the combinational input-FIFO read enable.
REQ-009 o_sel [0:N_PORTS-1]  output  N_PORTS each  SHALL be the combinational one-hot input select per output, driving the crossbar switch.
REQ-010 o_data_val [0:N_PORTS-1]  output  1 each  SHALL be the registered output-valid, aligned with the switch output register.
REQ-011 o_stall [0:N_PORTS-1]  output  1 each  SHALL flag starvation per output.
REQ-012 o_err  output  1  SHALL be a sticky flag for a malformed request.

Function
REQ-013 Input k SHALL request output j iff i_req_val[k]=1 and i_req[k] is exactly one-hot with bit j set.
REQ-014 i_req[k]=0 with i_req_val[k]=1 SHALL be treated as no request; a multi-hot value SHALL be ignored and SHALL set o_err at the next edge.
REQ-015 Output j SHALL grant only when i_en[j]=1 and at least one input requests j; at most one grant per output per cycle.
REQ-016 Arbitration SHALL be round-robin: search starts at ptr[j] and proceeds ptr[j]+1, ..., wrapping modulo N_PORTS; first requester wins.
REQ-017 On a grant to input k, ptr[j] SHALL become (k+1) mod N_PORTS at the next edge; with no grant, ptr[j] SHALL hold.
REQ-018 In a grant cycle, o_sel[j] SHALL equal one-hot k and o_pop[k] SHALL be 1, both in the same cycle (zero latency); otherwise o_sel[j]=0 and o_pop[k]=0.
REQ-019 o_data_val[j] SHALL be 1 exactly one cycle after a grant on output j, else 0.
REQ-020 Per-output stall counter SHALL increment (saturating at STALL_LIMIT) each cycle output j has a requester and i_en[j]=0, and SHALL clear on any grant to j or any cycle with no requester.
REQ-021 o_stall[j] SHALL be 1 while the counter equals STALL_LIMIT.
REQ-022 Simultaneous requests from all N_PORTS inputs to one output SHALL be served in strict rotation, one per i_en cycle, with no input waiting more than N_PORTS-1 grants.
REQ-023 Requests to distinct outputs SHALL all be granted in the same cycle when their i_en are 1.
REQ-024 o_err SHALL clear only on reset.

Reset
REQ-025 With reset_n=0: ptr[j]=0, o_data_val=0, stall counters=0, o_stall=0, o_err=0, all immediately (asynchronous).
REQ-026 While reset_n=0, o_pop and o_sel SHALL be forced to 0 regardless of inputs.
REQ-027 Reset asserted mid-operation SHALL drop any in-flight o_data_val; no grant is replayed after release.

Structure
REQ-028 N_PORTS, port-index constants (CORE=0, NORTH=1, EAST=2, SOUTH=3, WEST=4) and STALL_LIMIT default SHALL live in the shared MESH package.
REQ-029 One sub-module, mesh_rr_arbiter (one output's pointer plus priority search), SHALL be instantiated N_PORTS times.

Verification
REQ-030 Reset release, all i_req_val=0 -> o_pop=0, o_sel=0, o_data_val=0, o_err=0 for 10 cycles.
REQ-031 Inputs 0-4 all request output 2 (00100), i_en[2]=1 for 5 cycles -> o_sel[2] sequence 00001,00010,00100,01000,10000; o_data_val[2]=1 on cycles 2-6.
REQ-032 Input0->port1, input1->port2, input2->port3, input3->port4, input4->port0, all i_en=1 -> all five o_pop=1 in the same cycle.
REQ-033 Input 3 requests output 4 with i_en[4]=0 for 255 cycles -> o_stall[4]=1 at cycle 255; i_en[4]=1 -> grant, o_stall[4]=0 next cycle.
REQ-034 i_req[1]=00110 with i_req_val[1]=1 -> o_pop[1]=0, o_err=1 next cycle and held until reset.
REQ-035 reset_n driven low for 1 cycle during REQ-031 sequence -> o_data_val=0 immediately; after release, first grant goes to input 0.
